// File: rtl/nmcu_lane_dispatcher.sv
// Dispatches CPU instructions round-robin to compute lanes. Responses are
// returned to the CPU in acceptance order through a registered output stage.
module nmcu_lane_dispatcher #(
    parameter int unsigned NUM_LANES   = 4,
    parameter int unsigned INSTR_WIDTH = 64,
    parameter int unsigned RESP_WIDTH  = 64,
    parameter int unsigned ORDER_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cpu_instr_valid,
    input  logic [INSTR_WIDTH-1:0]          cpu_instruction,
    output logic                            cpu_instr_ready,
    output logic [NUM_LANES-1:0]            lane_cmd_valid_o,
    output logic [INSTR_WIDTH-1:0]          lane_cmd_o,
    input  logic [NUM_LANES-1:0]            lane_cmd_ready_i,
    input  logic [NUM_LANES-1:0]            lane_resp_valid_i,
    input  logic [NUM_LANES*RESP_WIDTH-1:0] lane_resp_i,
    output logic [NUM_LANES-1:0]            lane_resp_ready_o,
    output logic                            nmcu_resp_valid_o,
    input  logic                            nmcu_resp_ready_i,
    output logic [RESP_WIDTH-1:0]           nmcu_response_o,
    output logic [$clog2(ORDER_DEPTH+1)-1:0] outstanding_o,
    output logic                            protocol_err_o
);

    localparam int unsigned LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned PW = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
    localparam int unsigned CW = $clog2(ORDER_DEPTH + 1);

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    state_e                 state_q, state_d;
    logic [NUM_LANES-1:0]   busy_q, busy_d;
    logic [LW-1:0]          rr_ptr_q;
    logic [LW-1:0]          sel_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic                   run_q;
    logic [LW-1:0]          order_mem [ORDER_DEPTH];
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          count_q;
    logic                   resp_valid_q;
    logic [RESP_WIDTH-1:0]  resp_q;
    logic                   err_q;

    logic                   free_found;
    logic [LW-1:0]          free_idx;
    logic [LW-1:0]          rr_next;
    logic                   accept;
    logic                   cmd_fire;
    logic [LW-1:0]          head;
    logic                   fifo_nonempty;
    logic                   out_free;
    logic                   resp_fire;
    logic [RESP_WIDTH-1:0]  head_resp;
    logic                   idle_resp;

    // First free lane at or above rr_ptr, wrapping around.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (!free_found && !busy_q[(32'(rr_ptr_q) + i) % NUM_LANES]) begin
                free_found = 1'b1;
                free_idx   = LW'((32'(rr_ptr_q) + i) % NUM_LANES);
            end
        end
    end

    // Handshake decode, order-FIFO head and output-stage availability.
    always_comb begin
        rr_next         = LW'((32'(free_idx) + 1) % NUM_LANES);
        // run_q holds ready low until the first edge after reset release.
        cpu_instr_ready = run_q && (state_q == StIdle) && (count_q < CW'(ORDER_DEPTH)) &&
                          free_found;
        accept          = cpu_instr_ready && cpu_instr_valid;
        cmd_fire        = (state_q == StIssue) && lane_cmd_ready_i[sel_q];
        head            = order_mem[rd_ptr_q];
        fifo_nonempty   = (count_q != '0);
        out_free        = !resp_valid_q || nmcu_resp_ready_i;
        resp_fire       = fifo_nonempty && out_free && lane_resp_valid_i[head];
        head_resp       = lane_resp_i[32'(head)*RESP_WIDTH +: RESP_WIDTH];
        idle_resp       = |(lane_resp_valid_i & ~busy_q);
        lane_resp_ready_o = (fifo_nonempty && out_free) ? (NUM_LANES'(1) << head) : '0;
        lane_cmd_valid_o  = (state_q == StIssue) ? (NUM_LANES'(1) << sel_q) : '0;
        lane_cmd_o        = instr_q;
        nmcu_resp_valid_o = resp_valid_q;
        nmcu_response_o   = resp_q;
        outstanding_o     = count_q;
        protocol_err_o    = err_q;
    end

    // Next-state logic for the issue FSM and lane busy bits.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StIssue;
            StIssue: if (cmd_fire) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Freed and newly claimed lanes are always distinct: only free lanes are claimed.
        if (resp_fire) busy_d[head] = 1'b0;
        if (accept) busy_d[free_idx] = 1'b1;
    end

    // Control state, order FIFO and registered response stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            busy_q       <= '0;
            rr_ptr_q     <= '0;
            sel_q        <= '0;
            instr_q      <= '0;
            run_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
            err_q        <= 1'b0;
            for (int unsigned i = 0; i < ORDER_DEPTH; i++) order_mem[i] <= '0;
        end else begin
            run_q   <= 1'b1;
            state_q <= state_d;
            busy_q  <= busy_d;
            if (accept) begin
                instr_q             <= cpu_instruction;
                sel_q               <= free_idx;
                rr_ptr_q            <= rr_next;
                order_mem[wr_ptr_q] <= free_idx;
                wr_ptr_q            <= PW'((32'(wr_ptr_q) + 1) % ORDER_DEPTH);
            end
            if (resp_fire) begin
                rd_ptr_q <= PW'((32'(rd_ptr_q) + 1) % ORDER_DEPTH);
            end
            if (accept && !resp_fire) begin
                count_q <= count_q + CW'(1);
            end else if (!accept && resp_fire) begin
                count_q <= count_q - CW'(1);
            end
            if (resp_fire) begin
                resp_valid_q <= 1'b1;
                resp_q       <= head_resp;
            end else if (nmcu_resp_ready_i) begin
                resp_valid_q <= 1'b0;
            end
            if (idle_resp) err_q <= 1'b1;
        end
    end

endmodule

// File: doc/nmcu_lane_dispatcher.md
NMCU_LANE_DISPATCHER -- requirements
Module: nmcu_lane_dispatcher

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4: number of compute lanes, 2..8.
REQ-002 SHALL have parameter INSTR_WIDTH, default 64: instruction width.
REQ-003 SHALL have parameter RESP_WIDTH, default 64: response width.
REQ-004 SHALL have parameter ORDER_DEPTH, default 8: order-FIFO depth, power of 2.
REQ-005 SHALL use one clock; reset is asynchronous and active-low; ports named clk, rst_n.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 cpu_instr_valid  in  1  CPU instruction offered.
REQ-009 cpu_instruction  in  INSTR_WIDTH  CPU instruction payload.
REQ-010 cpu_instr_ready  out  1  instruction accepted when valid&ready.
REQ-011 lane_cmd_valid_o  out  NUM_LANES  one-hot command valid per lane.
REQ-012 lane_cmd_o  out  INSTR_WIDTH  shared command bus, meaningful for the valid lane.
REQ-013 lane_cmd_ready_i  in  NUM_LANES  per-lane command ready.
REQ-014 lane_resp_valid_i  in  NUM_LANES  per-lane response valid.
REQ-015 lane_resp_i  in  NUM_LANES*RESP_WIDTH  lane k response at bits [k*RESP_WIDTH +: RESP_WIDTH].
REQ-016 lane_resp_ready_o  out  NUM_LANES  per-lane response ready.
REQ-017 nmcu_resp_valid_o  out  1  registered response valid to CPU.
REQ-018 nmcu_resp_ready_i  in  1  CPU response ready.
REQ-019 nmcu_response_o  out  RESP_WIDTH  registered response payload.
REQ-020 outstanding_o  out  clog2(ORDER_DEPTH+1)  order-FIFO occupancy.
REQ-021 protocol_err_o  out  1  sticky: response from an idle lane.

Function
REQ-022 State machine SHALL have two states: IDLE, ISSUE.
REQ-023 IDLE: cpu_instr_ready=1 iff registered occupancy<ORDER_DEPTH and at least one lane busy bit is clear (registered values only).
REQ-024 On accept: latch instruction; select first free lane searching upward from rr_ptr with wrap; set its busy bit; push lane index into order FIFO; rr_ptr <= (sel+1) mod NUM_LANES; go to ISSUE.
REQ-025 ISSUE: cpu_instr_ready=0; lane_cmd_valid_o[sel]=1, others 0; lane_cmd_o=latched instruction; hold stable until lane_cmd_ready_i[sel]; then return to IDLE next cycle.
REQ-026 Peak throughput SHALL be one instruction per 2 cycles; accept-to-lane_cmd_valid latency 1 cycle.
REQ-027 Responses SHALL return to CPU in acceptance order: only the lane at order-FIFO head may get lane_resp_ready_o=1.
REQ-028 lane_resp_ready_o[head]=1 iff FIFO non-empty and (nmcu_resp_valid_o=0 or nmcu_resp_ready_i=1); all other bits 0.
REQ-029 On head-lane handshake: capture payload into nmcu_response_o, set nmcu_resp_valid_o next cycle, pop FIFO, clear that lane's busy bit.
REQ-030 nmcu_resp_valid_o/nmcu_response_o SHALL hold stable until nmcu_resp_ready_i; back-to-back captures allowed (full throughput on output).
REQ-031 Non-head lane responses SHALL stall (ready 0); no reordering, no drop.
REQ-032 Simultaneous push and pop: occupancy unchanged; freed lane becomes eligible only the following cycle.
REQ-033 lane_resp_valid_i[k]=1 while busy[k]=0 SHALL set protocol_err_o (sticky until reset); response ignored.
REQ-034 FIFO pointers SHALL wrap modulo ORDER_DEPTH; occupancy never exceeds ORDER_DEPTH nor underflows.

Reset
REQ-035 rst_n low SHALL immediately force: state IDLE, rr_ptr 0, busy bits 0, FIFO empty, all outputs 0 (cpu_instr_ready goes 1 on the first cycle after release).
REQ-036 Reset mid-ISSUE or with responses pending SHALL discard all in-flight state; no response is emitted after release.

Verification (NUM_LANES=4, ORDER_DEPTH=8)
REQ-037 Single op: instr 0xA1, lane0 ready -> lane_cmd_valid_o=0001 next cycle; lane0 resp 0x55 -> nmcu_response_o=0x55 one cycle later, outstanding_o 1->0.
REQ-038 Round robin: 4 instrs, lanes never respond -> dispatched to lanes 0,1,2,3; fifth instr sees cpu_instr_ready=0, outstanding_o=4.
REQ-039 Reorder: lanes 0..2 loaded with instrs I0..I2; lane2 then lane1 then lane0 respond -> CPU receives R0,R1,R2 in order; lanes 1,2 stall until head.
REQ-040 Backpressure: nmcu_resp_ready_i=0 for 10 cycles with response 0x77 held -> output stable, lane_resp_ready_o=0000, no loss.
REQ-041 Error/reset: lane3 resp valid while idle -> protocol_err_o=1 until rst_n pulse; rst_n low during ISSUE -> all outputs 0, outstanding_o=0.
